line_position_calc: RTL and testbench
=====================================

# line_position_calc

Downstream consumer of the 4-channel line-sensor ADC reader. Takes the reader's 12-bit conversion results as tagged samples, one channel at a time, and assembles them into four-channel frames. Each channel is thresholded with hysteresis into an on-line/off-line bit. The block then outputs a signed line-position error for the steering/PID stage, plus line-lost and junction flags.

## Interface
Parameters:
- THRESH_HI, 2048 — reading ≥ this marks a channel on-line.
- THRESH_LO, 1792 — reading < this marks a channel off-line; readings between the two keep the previous bit.
- LOST_FRAMES, 8 — consecutive all-off frames before line_lost asserts (range 1..255).

Ports:
- clk  in  1  — single clock; all logic on posedge.
- rst  in  1  — synchronous, active-low reset.
- sample_data  in  12  — unsigned ADC result from the reader.
- sample_ch  in  2  — channel index of sample_data (0 = ADC1 … 3 = ADC4).
- sample_valid  in  1  — one-cycle strobe; sample_data/sample_ch are valid when high.
- sensor_bits  out  4  — thresholded bits, bit i = channel i on-line.
- pos_error  out  8  — signed two's-complement position error.
- pos_valid  out  1  — one-cycle pulse when a new frame result is presented.
- line_lost  out  1  — level; no channel on-line for LOST_FRAMES frames.
- junction  out  1  — level; all four bits set in the latest frame.
- seq_err  out  1  — sticky; an out-of-order channel was seen.

## Operation
- Frame FSM has states COLLECT0, COLLECT1, COLLECT2, COLLECT3 and expects channels 0,1,2,3 in order.
  - A valid sample with the expected channel stores its bit and advances the state.
  - On channel 3, the frame completes and the FSM returns to COLLECT0.
- Out-of-order sample:
  - seq_err is set and the partial frame is discarded.
  - If the sample's channel is 0, it is accepted as the start of a new frame and the FSM goes to COLLECT1; otherwise the FSM goes to COLLECT0.
  - seq_err is cleared only by reset.
- Hysteresis per channel:
  - Compared against the channel's stored bit from the previous frame.
  - data ≥ THRESH_HI → 1; data < THRESH_LO → 0; otherwise unchanged.
  - Stored bits reset to 0.
- Channel weights: ch0 = −3, ch1 = −1, ch2 = +1, ch3 = +3.
  - With n = number of set bits and S = sum of their weights, pos_error = trunc(16·S/n), rounded toward zero.
  - Realised as a 16-entry constant table; no divider.
  - Values: 0001 → −48, 0011 → −32, 0111 → −16, 0110 → 0, 1111 → 0, 1110 → +16, 1100 → +32, 1000 → +48.
- last_err register holds the last pos_error from a frame with n > 0.
- Frame with n = 0:
  - pos_error = −127 if last_err < 0, +127 if last_err > 0, 0 if last_err = 0.
  - last_err is unchanged.
- lost_cnt (8-bit):
  - Increments on each completed frame with n = 0 and saturates at LOST_FRAMES.
  - Clears on any completed frame with n > 0.
  - line_lost = (lost_cnt == LOST_FRAMES).
- junction = 1 when the frame's bits == 4'b1111, else 0; updated once per completed frame.
- Reset values: sensor_bits = 0, pos_error = 0, pos_valid = 0, line_lost = 0, junction = 0, seq_err = 0, last_err = 0, lost_cnt = 0, FSM = COLLECT0.

## Timing
- Each sample_valid cycle processes exactly one sample; back-to-back valids on consecutive cycles must be accepted.
- Let cycle N be the sample_valid edge carrying channel 3 that completes a frame:
  - sensor_bits updates at N+1.
  - pos_error, junction, line_lost and the pos_valid pulse update together at N+2.
  - pos_valid is high for exactly one cycle.
- Outputs hold between frames.
- The pipeline must sustain a frame every 4 cycles; a new frame completing at N+1 does not disturb the N+2 result of the previous frame.
- Reset low on any edge overrides everything, including mid-frame and in-flight pipeline stages. On release no pos_valid is produced until a full new frame completes.

## Test plan
- Reset then frame ch0..3 = 3000, 100, 100, 100 → sensor_bits = 0001; pos_error = −48 (0xD0) with pos_valid at N+2; junction = 0; line_lost = 0.
- Hysteresis on ch0:
  - Frame with ch0 = 1846 (0x736) from reset → bit 0 = 0.
  - Then a frame with ch0 = 2500 → bit 0 = 1.
  - Then a frame with ch0 = 1846 → bit 0 stays 1.
  - Then a frame with ch0 = 1700 → bit 0 = 0.
- All four channels = 4000 → bits = 1111, junction = 1, pos_error = 0. Next frame 4000, 4000, 4000, 100 → pos_error = −16, junction = 0.
- Line lost:
  - Frame 1100 pattern giving +32, then 8 frames of all-zero readings.
  - Each all-zero frame gives pos_error = +127.
  - line_lost rises with the 8th frame's pos_valid.
  - A subsequent 0110 frame → line_lost = 0, pos_error = 0.
- Sequence error: ch0, ch1, then ch3 → seq_err = 1, no pos_valid. Then a full 0..3 frame → normal result with seq_err still 1.
- Reset asserted after ch0..ch2 of a frame → all outputs at reset values. A following ch3 alone produces no pos_valid (it sets seq_err).

Source files
------------

// File: rtl/line_position_calc_if.sv
// Sample stream in from the ADC reader and frame results out to the steering stage.
interface line_position_calc_if;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;
  logic        sample_valid;
  logic [3:0]  sensor_bits;
  logic [7:0]  pos_error;
  logic        pos_valid;
  logic        line_lost;
  logic        junction;
  logic        seq_err;

  modport master (
    output sample_data, sample_ch, sample_valid,
    input  sensor_bits, pos_error, pos_valid, line_lost, junction, seq_err
  );

  modport slave (
    input  sample_data, sample_ch, sample_valid,
    output sensor_bits, pos_error, pos_valid, line_lost, junction, seq_err
  );
endinterface

// File: rtl/line_position_calc.sv
// Assembles tagged ADC samples into 4-channel frames, thresholds with hysteresis,
// and produces a signed line-position error plus line-lost / junction flags.
module line_position_calc #(
  parameter int THRESH_HI   = 2048,
  parameter int THRESH_LO   = 1792,
  parameter int LOST_FRAMES = 8
) (
  input logic           clk,
  input logic           rst,
  line_position_calc_if.slave bus
);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {COLLECT0, COLLECT1, COLLECT2, COLLECT3} state_t;

  state_t             state_q;
  logic [2:0]         frame_q;
  logic [3:0]         sensor_bits_q;
  logic [STAGES:0]    vld_pipe;
  logic signed [7:0]  pos_error_q;
  logic signed [7:0]  last_err_q;
  logic [7:0]         lost_cnt_q;
  logic               line_lost_q;
  logic               junction_q;
  logic               seq_err_q;

  logic               hit;
  logic               hyst_bit;
  logic               frame_done;
  logic signed [7:0]  tbl_err;
  logic signed [7:0]  err_d;
  logic [7:0]         lost_d;
  logic               none_on;

  // Hysteresis reference is the channel's bit from the last completed frame.
  always_comb begin
    hyst_bit = sensor_bits_q[bus.sample_ch];
    if (bus.sample_data >= 12'(THRESH_HI))     hyst_bit = 1'b1;
    else if (bus.sample_data < 12'(THRESH_LO)) hyst_bit = 1'b0;
  end

  assign hit        = bus.sample_valid && (bus.sample_ch == state_q);
  assign frame_done = hit && (state_q == COLLECT3);

  // trunc(16*S/n) with weights -3,-1,+1,+3 on ch0..ch3
  always_comb begin
    tbl_err = 8'sd0;
    case (sensor_bits_q)
      4'b0001: tbl_err = -8'sd48;
      4'b0010: tbl_err = -8'sd16;
      4'b0011: tbl_err = -8'sd32;
      4'b0100: tbl_err =  8'sd16;
      4'b0101: tbl_err = -8'sd16;
      4'b0111: tbl_err = -8'sd16;
      4'b1000: tbl_err =  8'sd48;
      4'b1010: tbl_err =  8'sd16;
      4'b1011: tbl_err = -8'sd5;
      4'b1100: tbl_err =  8'sd32;
      4'b1101: tbl_err =  8'sd5;
      4'b1110: tbl_err =  8'sd16;
      default: tbl_err = 8'sd0;
    endcase
  end

  assign none_on = (sensor_bits_q == 4'b0000);

  always_comb begin
    err_d  = tbl_err;
    lost_d = 8'd0;
    if (none_on) begin
      if (last_err_q < 0)      err_d = -8'sd127;
      else if (last_err_q > 0) err_d =  8'sd127;
      else                     err_d =  8'sd0;
      lost_d = (lost_cnt_q == 8'(LOST_FRAMES)) ? lost_cnt_q : lost_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= COLLECT0;
      frame_q       <= '0;
      sensor_bits_q <= '0;
      vld_pipe      <= '0;
      pos_error_q   <= '0;
      last_err_q    <= '0;
      lost_cnt_q    <= '0;
      line_lost_q   <= 1'b0;
      junction_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], frame_done};
      if (bus.sample_valid) begin
        if (hit) begin
          case (state_q)
            COLLECT0: begin frame_q[0] <= hyst_bit; state_q <= COLLECT1; end
            COLLECT1: begin frame_q[1] <= hyst_bit; state_q <= COLLECT2; end
            COLLECT2: begin frame_q[2] <= hyst_bit; state_q <= COLLECT3; end
            default: begin
              sensor_bits_q <= {hyst_bit, frame_q};
              state_q       <= COLLECT0;
            end
          endcase
        end else begin
          // Out-of-order: drop the partial frame; a ch0 restarts a frame.
          seq_err_q <= 1'b1;
          if (bus.sample_ch == 2'd0) begin
            frame_q[0] <= hyst_bit;
            state_q    <= COLLECT1;
          end else begin
            state_q    <= COLLECT0;
          end
        end
      end
      if (vld_pipe[0]) begin
        pos_error_q <= err_d;
        junction_q  <= &sensor_bits_q;
        lost_cnt_q  <= lost_d;
        line_lost_q <= (lost_d == 8'(LOST_FRAMES));
        if (!none_on) last_err_q <= tbl_err;
      end
    end
  end

  assign bus.sensor_bits = sensor_bits_q;
  assign bus.pos_error   = pos_error_q;
  assign bus.pos_valid   = vld_pipe[STAGES];
  assign bus.line_lost   = line_lost_q;
  assign bus.junction    = junction_q;
  assign bus.seq_err     = seq_err_q;
endmodule

// File: tb/tb_line_position_calc.sv
// Directed-vector bench for line_position_calc with hand-computed expectations.
module tb_line_position_calc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  line_position_calc_if bus();

  line_position_calc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk);
    bus.sample_ch    = ch;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Sends one in-order frame and samples outputs at N+1, N+2 and N+3.
  task automatic run_frame(input logic [11:0] d0, d1, d2, d3,
                           output logic [3:0] bits, output logic pv_early,
                           output logic pv, output logic pv_late,
                           output logic signed [7:0] err,
                           output logic lost, output logic junc);
    drive(2'd0, d0);
    drive(2'd1, d1);
    drive(2'd2, d2);
    drive(2'd3, d3);
    idle();
    bits     = bus.sensor_bits;
    pv_early = bus.pos_valid;
    @(negedge clk);
    pv   = bus.pos_valid;
    err  = bus.pos_error;
    lost = bus.line_lost;
    junc = bus.junction;
    @(negedge clk);
    pv_late = bus.pos_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample_ch    = 2'd0;
    bus.sample_data  = 12'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.sensor_bits, bus.pos_error, bus.pos_valid, bus.line_lost, bus.junction, bus.seq_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bits=%b err=%0d pv=%b lost=%b junc=%b seq=%b expected all zero",
               bus.sensor_bits, $signed(bus.pos_error), bus.pos_valid, bus.line_lost, bus.junction, bus.seq_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] b; logic pe, pv, pl, lo, ju; logic signed [7:0] e;
    run_frame(12'd3000, 12'd100, 12'd100, 12'd100, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b0001) begin n_fail++; $display("FAIL basic_bits: got %b expected 0001", b); end
    n_chk++; if ({pe, pv, pl} !== 3'b010) begin n_fail++; $display("FAIL basic_pv_timing: got %b expected 010", {pe, pv, pl}); end
    n_chk++; if (e !== -8'sd48) begin n_fail++; $display("FAIL basic_err: got %0d expected -48", e); end
    n_chk++; if ({lo, ju} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got lost=%b junc=%b expected 0 0", lo, ju); end
  endtask

  task automatic test_hysteresis();
    logic [11:0] d0 [7] = '{12'd1846, 12'd2500, 12'd1846, 12'd1700, 12'd0, 12'd0, 12'd0};
    logic [11:0] d2 [7] = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd2048, 12'd1792, 12'd1791};
    logic [3:0]  xb [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    int          xe [7] = '{0, -48, -48, -127, 16, 16, 127};
    logic [3:0] b; logic pe, pv, pl, lo, ju; logic signed [7:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_frame(d0[i], 12'd0, d2[i], 12'd0, b, pe, pv, pl, e, lo, ju);
      n_chk++; if (b !== xb[i]) begin n_fail++; $display("FAIL hyst_bits[%0d]: got %b expected %b", i, b, xb[i]); end
      n_chk++; if (e !== xe[i] || pv !== 1'b1) begin n_fail++; $display("FAIL hyst_err[%0d]: got %0d pv=%b expected %0d pv=1", i, e, pv, xe[i]); end
    end
  endtask

  task automatic test_junction();
    logic [3:0] b; logic pe, pv, pl, lo, ju; logic signed [7:0] e;
    run_frame(12'd4000, 12'd4000, 12'd4000, 12'd4000, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b1111 || ju !== 1'b1 || e !== 8'sd0) begin n_fail++; $display("FAIL junc_all: got bits=%b junc=%b err=%0d expected 1111 1 0", b, ju, e); end
    run_frame(12'd4000, 12'd4000, 12'd4000, 12'd100, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b0111 || ju !== 1'b0 || e !== -8'sd16) begin n_fail++; $display("FAIL junc_drop: got bits=%b junc=%b err=%0d expected 0111 0 -16", b, ju, e); end
    run_frame(12'd0, 12'd0, 12'd0, 12'd0, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (e !== -8'sd127 || ju !== 1'b0) begin n_fail++; $display("FAIL junc_neg_lost: got err=%0d junc=%b expected -127 0", e, ju); end
  endtask

  task automatic test_line_lost();
    logic [3:0] b; logic pe, pv, pl, lo, ju; logic signed [7:0] e;
    run_frame(12'd0, 12'd0, 12'd4000, 12'd4000, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b1100 || e !== 8'sd32 || lo !== 1'b0) begin n_fail++; $display("FAIL lost_start: got bits=%b err=%0d lost=%b expected 1100 32 0", b, e, lo); end
    for (int i = 1; i <= 9; i++) begin
      run_frame(12'd0, 12'd0, 12'd0, 12'd0, b, pe, pv, pl, e, lo, ju);
      n_chk++; if (e !== 8'sd127) begin n_fail++; $display("FAIL lost_err[%0d]: got %0d expected 127", i, e); end
      n_chk++; if (lo !== (i >= 8)) begin n_fail++; $display("FAIL lost_flag[%0d]: got %b expected %b", i, lo, (i >= 8)); end
    end
    run_frame(12'd0, 12'd4000, 12'd4000, 12'd0, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b0110 || e !== 8'sd0 || lo !== 1'b0) begin n_fail++; $display("FAIL lost_recover: got bits=%b err=%0d lost=%b expected 0110 0 0", b, e, lo); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d [8] = '{12'd4000, 12'd4000, 12'd100, 12'd100, 12'd100, 12'd100, 12'd4000, 12'd4000};
    logic pv_s [8];
    logic signed [7:0] e_s [8];
    logic [3:0] b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pv_s[i] = bus.pos_valid;
      e_s[i]  = bus.pos_error;
      bus.sample_ch    = 2'(i % 4);
      bus.sample_data  = d[i];
      bus.sample_valid = 1'b1;
    end
    idle();
    b = bus.sensor_bits;
    n_chk++; if (pv_s[5] !== 1'b1 || e_s[5] !== -8'sd32) begin n_fail++; $display("FAIL b2b_first: got pv=%b err=%0d expected 1 -32", pv_s[5], e_s[5]); end
    n_chk++; if (pv_s[6] !== 1'b0 || pv_s[7] !== 1'b0 || e_s[7] !== -8'sd32) begin n_fail++; $display("FAIL b2b_hold: got pv=%b%b err=%0d expected 00 -32", pv_s[6], pv_s[7], e_s[7]); end
    n_chk++; if (b !== 4'b1100 || bus.pos_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bits: got %b pv=%b expected 1100 0", b, bus.pos_valid); end
    @(negedge clk);
    n_chk++; if (bus.pos_valid !== 1'b1 || $signed(bus.pos_error) !== 8'sd32) begin n_fail++; $display("FAIL b2b_second: got pv=%b err=%0d expected 1 32", bus.pos_valid, $signed(bus.pos_error)); end
  endtask

  task automatic test_seq_err();
    logic [3:0] b; logic pe, pv, pl, lo, ju; logic signed [7:0] e;
    logic any_pv;
    n_chk++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_pre: got %b expected 0", bus.seq_err); end
    drive(2'd0, 12'd3000);
    drive(2'd1, 12'd100);
    drive(2'd3, 12'd100);
    idle();
    any_pv = bus.pos_valid;
    repeat (3) begin @(negedge clk); any_pv |= bus.pos_valid; end
    n_chk++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_set: got %b expected 1", bus.seq_err); end
    n_chk++; if (any_pv !== 1'b0) begin n_fail++; $display("FAIL seq_no_pv: got %b expected 0", any_pv); end
    run_frame(12'd3000, 12'd100, 12'd100, 12'd100, b, pe, pv, pl, e, lo, ju);
    n_chk++; if (b !== 4'b0001 || e !== -8'sd48 || pv !== 1'b1) begin n_fail++; $display("FAIL seq_recover: got bits=%b err=%0d pv=%b expected 0001 -48 1", b, e, pv); end
    n_chk++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %b expected 1", bus.seq_err); end
  endtask

  task automatic test_reset_midframe();
    logic any_pv;
    drive(2'd0, 12'd4000);
    drive(2'd1, 12'd4000);
    drive(2'd2, 12'd4000);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.sensor_bits, bus.pos_error, bus.pos_valid, bus.line_lost, bus.junction, bus.seq_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got bits=%b err=%0d pv=%b lost=%b junc=%b seq=%b expected all zero",
               bus.sensor_bits, $signed(bus.pos_error), bus.pos_valid, bus.line_lost, bus.junction, bus.seq_err);
    end
    rst = 1'b1;
    drive(2'd3, 12'd4000);
    idle();
    any_pv = bus.pos_valid;
    repeat (3) begin @(negedge clk); any_pv |= bus.pos_valid; end
    n_chk++; if (any_pv !== 1'b0 || bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL midreset_ch3: got pv=%b seq=%b expected 0 1", any_pv, bus.seq_err); end
    n_chk++; if (bus.sensor_bits !== 4'b0000) begin n_fail++; $display("FAIL midreset_bits: got %b expected 0000", bus.sensor_bits); end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_ch    = 2'd0;
    bus.sample_data  = 12'd0;
    test_reset();
    test_basic();
    test_hysteresis();
    test_junction();
    test_line_lost();
    test_back_to_back();
    test_seq_err();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
